// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b), LSB first, with start/done handshake.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;
`ifdef SUB_OVF_EN
  logic             a_msb_q, b_msb_q;
`endif

  logic             ai, bi, d, br_d, last;
  logic [WIDTH-1:0] res_d;

  // Single full-subtractor cell plus result shift-in.
  always_comb begin
    ai    = a_q[0];
    bi    = b_q[0];
    d     = ai ^ bi ^ br_q;
    br_d  = (~ai & bi) | (~(ai ^ bi) & br_q);
    res_d = {d, res_q[WIDTH-1:1]};
    last  = (cnt_q == LastCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StShift;
`ifdef SUB_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end
        end
        StShift: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CntW'(1);
          // Final bit: publish the result including the bit computed this edge.
          if (last) begin
            diff    <= res_d;
            bout    <= br_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
`ifdef SUB_OVF_EN
            ovf     <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 4): table vectors, handshake,
// back-to-back, mid-operation reset and random operands against a scoreboard.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", {28'd0, diff}, {28'd0, e.diff});
        check("bout", {31'd0, bout}, {31'd0, e.bout});
`ifdef SUB_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Entered and left on a negedge; leaves at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input bit inject);
    int lat;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    sb.push_back('{diff: ed, bout: eb, ovf: eo});
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("hold_diff", {28'd0, diff}, {28'd0, last_diff});
    check("hold_bout", {31'd0, bout}, {31'd0, last_bout});
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!done) check("busy_in_flight", {31'd0, busy}, 32'd1);
      if (inject && lat == 1) begin
        start = 1'b1;
        a     = 4'b0000;
        b     = 4'b0001;
      end else begin
        start = 1'b0;
      end
    end
    check("latency", lat, W);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    last_diff = ed;
    last_bout = eb;
  endtask

  vec_t vecs[10];

  initial begin
    logic [W-1:0] ra, rb, rd;
    logic         rbo, ro;

    vecs[0] = '{a: 4'b0000, b: 4'b0000, diff: 4'b0000, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 4'b1101, b: 4'b1011, diff: 4'b0010, bout: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 4'b0001, b: 4'b1111, diff: 4'b0010, bout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 4'b1111, b: 4'b0001, diff: 4'b1110, bout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 4'b0111, b: 4'b1000, diff: 4'b1111, bout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 4'b0101, b: 4'b0011, diff: 4'b0010, bout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 4'b1000, b: 4'b0001, diff: 4'b0111, bout: 1'b0, ovf: 1'b1};
    vecs[7] = '{a: 4'b0000, b: 4'b0001, diff: 4'b1111, bout: 1'b1, ovf: 1'b0};
    vecs[8] = '{a: 4'b1001, b: 4'b1001, diff: 4'b0000, bout: 1'b0, ovf: 1'b0};
    vecs[9] = '{a: 4'b0110, b: 4'b0011, diff: 4'b0011, bout: 1'b0, ovf: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {28'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;

    // Table: first op starts on the first edge after release; odd entries chain
    // back-to-back (start driven during the done cycle).
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, vecs[i].ovf, 1'b0);
      if (i % 2 == 1) @(negedge clk);
    end

    // start pulsed at E2 of 13 - 11 must be ignored.
    @(negedge clk);
    run_op(4'b1101, 4'b1011, 4'b0010, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("ignored_start_busy", {31'd0, busy}, 32'd0);
    check("ignored_start_diff", {28'd0, diff}, 32'h2);

    // Make outputs nonzero, then reset after E2 of 13 - 11.
    run_op(4'b1111, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 4'b1101;
    b     = 4'b1011;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {28'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
`ifdef SUB_OVF_EN
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    last_diff = '0;
    last_bout = 1'b0;
    run_op(4'b0110, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);

    // Random operands against a reference model.
    for (int i = 0; i < 16; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rd  = ra - rb;
      rbo = (ra < rb);
      ro  = (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
      if (i % 3 == 0) @(negedge clk);
      run_op(ra, rb, rd, rbo, ro, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
